pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid buffer. It replaces the fixed-width, stall/flush-only inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single block that each stage instantiates. The skid buffer gives the upstream stage a registered `in_ready`, which removes the combinational stall path through the whole pipeline.

## Interface
- `WIDTH`, 64: payload bits (e.g. PC+4 concatenated with the instruction word).
- `FLUSH_VALUE`, `{WIDTH{1'b0}}`: payload loaded on reset and on flush. 32'b0 is the NOP bubble.
- `SKID`, 1: 1 adds a 2-entry skid buffer with registered `in_ready`. 0 gives a single register with combinational `in_ready`.
- `clk  in  1`: rising-edge clock, the only clock.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: upstream presents a payload.
- `in_ready  out  1`: stage accepts this cycle.
- `in_data  in  WIDTH`: upstream payload.
- `out_valid  out  1`: downstream payload valid.
- `out_ready  in  1`: downstream accepts. Low means stall.
- `out_data  out  WIDTH`: payload held in the main register.
- `flush  in  1`: discard all held payloads (branch/jump redirect).
- `count  out  2`: entries held, 0..2. Maximum is 1 when SKID=0.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - `out_data` is stable while `out_valid && !out_ready`.
- SKID=1 state machine, with the state encoded in `count`:
  - EMPTY(0), input transfer → ONE: main <= `in_data`.
  - ONE(1), input transfer with no output transfer → TWO: skid <= `in_data`.
  - ONE, output transfer with no input transfer → EMPTY.
  - ONE, both transfers → ONE: main <= `in_data`.
  - TWO(2), output transfer → ONE: main <= skid. No input transfer is possible in TWO.
- `in_ready` is a register, equal to `(next_count != 2)`.
- `out_valid = (count != 0)`.
- SKID=0 behaviour:
  - `in_ready = !out_valid || out_ready`, combinational.
  - main loads on input transfer.
  - `out_valid` clears on an output transfer with no input transfer.
- Flush: main and skid <= FLUSH_VALUE, `count` <= 0, `out_valid` <= 0, `in_ready` <= 1.
- Flush beats a simultaneous input transfer: the payload is dropped and the upstream sees it consumed.
- A simultaneous output transfer still completes.
- Reset beats flush. The reset state matches the flush state.
- Once emptied, the skid register is not guaranteed to hold FLUSH_VALUE. It is never visible on `out_data`.

## Timing
- Reset values:
  - `out_valid`=0
  - `out_data`=FLUSH_VALUE
  - `count`=0
  - `in_ready`=1 on the first edge after `rst` deasserts. It is held 0 while `rst`=1 for SKID=1.
- Latency: an input transfer at edge N gives `out_valid`=1 and `out_data` equal to the payload after edge N. Data passes through in one cycle.
- Throughput is 1 per cycle in steady state. The skid entry is used only when `out_ready` falls.
- After `out_ready` falls, SKID=1 accepts exactly one more payload, then drops `in_ready` the following cycle.
- `in_ready` rises the cycle after TWO drains to ONE.
- Ordering is strictly FIFO. No payload is duplicated or lost, except on flush.
- `rst` or `flush` mid-stall returns to EMPTY in one edge.

## Structure
- Shared header/package `pipe_pkg` holds `NOP_INSTR` = 32'h0000_0000, the widths `PC_W`/`INSTR_W` = 32, and `count` encodings `CNT_EMPTY`/`CNT_ONE`/`CNT_TWO`.
- Single module. The main register and the skid register are inline, with `generate if (SKID)` selecting the path.
- No sub-module.

## Test plan
- Reset, then stream 0x1..0x8 with `out_ready`=1: outputs appear 1 cycle later, one per cycle, `count`=1 throughout.
- SKID=1, `out_ready`=0 during 0xA then 0xB: 0xA is held on `out_data`, 0xB is in skid, `count`=2, `in_ready`=0 next cycle. Raise `out_ready`: the outputs are 0xA then 0xB, and `in_ready` returns to 1.
- `flush`=1 with `count`=2 and `in_valid`=1 (0xC): next cycle `out_valid`=0, `out_data`=FLUSH_VALUE, `count`=0. 0xC never appears.
- SKID=0, `out_ready`=0 while holding 0xD: `in_ready`=0 in the same cycle, and 0xD is held until `out_ready`=1.
- `rst`=1 asserted mid-stream with `count`=2: after one edge `out_valid`=0, `count`=0, and no stale payload appears after release.
- Random `in_valid`/`out_ready`/`flush` over 10k cycles against a scoreboard: order preserved, and no loss except flushed entries.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: instruction/PC widths,
// the NOP bubble and the occupancy encoding reported on count.
package pipe_pkg;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_TWO   = 2'd2
   } cnt_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and flush.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
   parameter bit               SKID        = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       count
);

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   generate
      if (SKID) begin : g_skid
         cnt_e             state_q, state_d;
         logic [WIDTH-1:0] main_p1;
         logic [WIDTH-1:0] skid_p1;
         logic             rdy_q;
         logic             load_main;
         logic             load_skid;
         logic             main_from_skid;

         always_comb begin
            state_d        = state_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            if (flush) begin
               state_d = CNT_EMPTY;
            end else begin
               case (state_q)
                  CNT_EMPTY: begin
                     if (in_xfer) begin
                        state_d   = CNT_ONE;
                        load_main = 1'b1;
                     end
                  end
                  CNT_ONE: begin
                     if (in_xfer && !out_xfer) begin
                        state_d   = CNT_TWO;
                        load_skid = 1'b1;
                     end else if (!in_xfer && out_xfer) begin
                        state_d = CNT_EMPTY;
                     end else if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                     end
                  end
                  CNT_TWO: begin
                     // in_ready is low here, so only the drain can happen
                     if (out_xfer) begin
                        state_d        = CNT_ONE;
                        main_from_skid = 1'b1;
                     end
                  end
                  default: state_d = CNT_EMPTY;
               endcase
            end
         end

         // ---- stage boundary: main/skid registers ----
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= CNT_EMPTY;
               rdy_q   <= 1'b0;
               main_p1 <= FLUSH_VALUE;
               skid_p1 <= FLUSH_VALUE;
            end else begin
               state_q <= state_d;
               rdy_q   <= (state_d != CNT_TWO);
               if (flush) begin
                  main_p1 <= FLUSH_VALUE;
                  skid_p1 <= FLUSH_VALUE;
               end else begin
                  if (load_main) begin
                     main_p1 <= in_data;
                  end else if (main_from_skid) begin
                     main_p1 <= skid_p1;
                  end
                  if (load_skid) begin
                     skid_p1 <= in_data;
                  end
               end
            end
         end

         assign in_ready  = rdy_q;
         assign out_valid = (state_q != CNT_EMPTY);
         assign out_data  = main_p1;
         assign count     = state_q;
      end else begin : g_plain
         logic             vld_p1;
         logic [WIDTH-1:0] main_p1;

         // ---- stage boundary: single main register ----
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p1  <= 1'b0;
               main_p1 <= FLUSH_VALUE;
            end else if (flush) begin
               vld_p1  <= 1'b0;
               main_p1 <= FLUSH_VALUE;
            end else if (in_xfer) begin
               vld_p1  <= 1'b1;
               main_p1 <= in_data;
            end else if (out_xfer) begin
               vld_p1 <= 1'b0;
            end
         end

         assign in_ready  = !vld_p1 || out_ready;
         assign out_valid = vld_p1;
         assign out_data  = main_p1;
         assign count     = {1'b0, vld_p1};
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a plain instance share stimulus and are
// each checked every cycle against a queue model, plus literal spot checks.
module tb_pipe_stage_reg;

   localparam int W = 32;
   localparam logic [W-1:0] F = 32'hA5A5_0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, out_ready, flush;
   logic [W-1:0] in_data;

   logic         s_rdy, s_ov, n_rdy, n_ov;
   logic [W-1:0] s_od, n_od;
   logic [1:0]   s_cnt, n_cnt;

   pipe_stage_reg #(.WIDTH(W), .FLUSH_VALUE(F), .SKID(1'b1)) dut_skid (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_rdy), .in_data(in_data),
      .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od), .flush(flush), .count(s_cnt));

   pipe_stage_reg #(.WIDTH(W), .FLUSH_VALUE(F), .SKID(1'b0)) dut_plain (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_rdy), .in_data(in_data),
      .out_valid(n_ov), .out_ready(out_ready), .out_data(n_od), .flush(flush), .count(n_cnt));

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [W-1:0] sq[$];
   logic [W-1:0] nq[$];
   bit           s_rdy_m = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("s_valid", W'(s_ov), W'(sq.size() > 0));
      chk("s_count", W'(s_cnt), W'(sq.size()));
      chk("s_ready", W'(s_rdy), W'(s_rdy_m));
      if (sq.size() > 0) chk("s_data", s_od, sq[0]);
      chk("n_valid", W'(n_ov), W'(nq.size() > 0));
      chk("n_count", W'(n_cnt), W'(nq.size()));
      chk("n_ready", W'(n_rdy), W'(nq.size() == 0 || out_ready));
      if (nq.size() > 0) chk("n_data", n_od, nq[0]);
   endtask

   task automatic update();
      bit s_in, s_out, n_in, n_out;
      if (rst) begin
         sq.delete();
         nq.delete();
         s_rdy_m = 1'b0;
         return;
      end
      s_in  = in_valid && s_rdy_m;
      s_out = (sq.size() > 0) && out_ready;
      n_in  = in_valid && (nq.size() == 0 || out_ready);
      n_out = (nq.size() > 0) && out_ready;
      if (s_out) void'(sq.pop_front());
      if (n_out) void'(nq.pop_front());
      if (flush) begin
         sq.delete();
         nq.delete();
         s_rdy_m = 1'b1;
      end else begin
         if (s_in) sq.push_back(in_data);
         if (n_in) nq.push_back(in_data);
         s_rdy_m = (sq.size() != 2);
      end
   endtask

   task automatic cycle(input bit r, input bit iv, input logic [W-1:0] d,
                        input bit ordy, input bit fl);
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      if (chk_en) compare();
      @(posedge clk);
      update();
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk_en = 1'b1;
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("rst_s_valid", W'(s_ov), '0);
      chk("rst_s_count", W'(s_cnt), '0);
      chk("rst_s_data", s_od, F);
      chk("rst_n_data", n_od, F);
      chk("rst_s_ready", W'(s_rdy), '0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("rel_s_ready", W'(s_rdy), 32'd1);

      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
         chk("stream_s_data", s_od, W'(i));
         chk("stream_s_count", W'(s_cnt), 32'd1);
         chk("stream_n_data", n_od, W'(i));
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

      cycle(1'b0, 1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'hB, 1'b0, 1'b0);
      chk("stall_s_data", s_od, 32'hA);
      chk("stall_s_count", W'(s_cnt), 32'd2);
      chk("stall_s_ready", W'(s_rdy), '0);
      chk("stall_n_data", n_od, 32'hA);
      chk("stall_n_ready", W'(n_rdy), '0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("drain_s_data", s_od, 32'hB);
      chk("drain_s_count", W'(s_cnt), 32'd1);
      chk("drain_s_ready", W'(s_rdy), 32'd1);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("drained_s_valid", W'(s_ov), '0);

      cycle(1'b0, 1'b1, 32'hD, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'hE, 1'b0, 1'b0);
      chk("hold_n_data", n_od, 32'hD);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

      cycle(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h12, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'hC, 1'b0, 1'b1);
      chk("flush_s_valid", W'(s_ov), '0);
      chk("flush_s_data", s_od, F);
      chk("flush_s_count", W'(s_cnt), '0);
      chk("flush_s_ready", W'(s_rdy), 32'd1);
      chk("flush_n_data", n_od, F);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

      cycle(1'b0, 1'b1, 32'h21, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h23, 1'b0, 1'b0);
      chk("midrst_s_valid", W'(s_ov), '0);
      chk("midrst_s_count", W'(s_cnt), '0);
      chk("midrst_n_valid", W'(n_ov), '0);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("postrst_s_valid", W'(s_ov), '0);
      chk("postrst_s_ready", W'(s_rdy), 32'd1);

      for (int i = 0; i < 10000; i++) begin
         cycle($urandom_range(0, 999) < 3, $urandom_range(0, 9) < 7, $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
